// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the systolic array front end
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    CLEAR,
    FEED,
    DONE
  } feeder_state_t;

  localparam int TPU_WIDTH = 8;

  function automatic int step_width(input int n);
    return $clog2(3 * n - 2);
  endfunction

endpackage

// File: rtl/feeder_skew_select.sv
// rtl/feeder_skew_select.sv - picks the element of one row/column due on a lane at step t
module feeder_skew_select #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int SW    = 2
) (
  input  logic [SW-1:0]      t,
  input  logic [SW-1:0]      lane,
  input  logic [N*WIDTH-1:0] vec,
  output logic [WIDTH-1:0]   elem
);

  logic [SW-1:0] k;

  // Lane l lags lane 0 by l steps, so it shows element t-l while that index is in range.
  always_comb begin
    k    = t - lane;
    elem = '0;
    if (t >= lane) begin
      for (int e = 0; e < N; e++) begin
        if (k == SW'(e)) elem = vec[e*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads A/B serially and drives skewed operands into the PE array
// FEEDER_AUTOSTART_EN: run begins automatically after the final load beat.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH = TPU_WIDTH,
  parameter int N     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [WIDTH-1:0]   load_data,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               clear_out,
  output logic [N*WIDTH-1:0] a_row,
  output logic [N*WIDTH-1:0] b_col
);

  localparam int SW = step_width(N);
  localparam int NE = 2 * N * N;
  localparam int IW = $clog2(NE);
  localparam logic [SW-1:0] LAST_STEP = SW'(3 * N - 3);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NE - 1);

  feeder_state_t state;
  logic [IW-1:0] idx;
  logic [IW-1:0] widx;
  logic [SW-1:0] step;
  logic [SW-1:0] nxt_step;
  logic          accept;
  logic [WIDTH-1:0] mem [NE];
  logic [N-1:0][N*WIDTH-1:0] a_vec;
  logic [N-1:0][N*WIDTH-1:0] b_vec;
  logic [N*WIDTH-1:0] a_skew;
  logic [N*WIDTH-1:0] b_skew;

  assign accept   = load_valid && load_ready;
  assign widx     = (state == LOADED) ? '0 : idx;
  // Outputs are registered, so the selectors look one step ahead of the displayed step.
  assign nxt_step = (state == CLEAR) ? '0 : step + SW'(1);

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_elem
      assign a_vec[i][k*WIDTH +: WIDTH] = mem[i*N + k];
      assign b_vec[i][k*WIDTH +: WIDTH] = mem[N*N + k*N + i];
    end
    feeder_skew_select #(.WIDTH(WIDTH), .N(N), .SW(SW)) u_a_sel (
      .t(nxt_step), .lane(SW'(i)), .vec(a_vec[i]), .elem(a_skew[i*WIDTH +: WIDTH])
    );
    feeder_skew_select #(.WIDTH(WIDTH), .N(N), .SW(SW)) u_b_sel (
      .t(nxt_step), .lane(SW'(i)), .vec(b_vec[i]), .elem(b_skew[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) mem[widx] <= load_data;
  end

`ifdef FEEDER_AUTOSTART_EN
  logic unused_start;
  assign unused_start = start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      step       <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      clear_out  <= 1'b0;
      a_row      <= '0;
      b_col      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef FEEDER_AUTOSTART_EN
              state      <= CLEAR;
              clear_out  <= 1'b1;
              busy       <= 1'b1;
              load_ready <= 1'b0;
`else
              state      <= LOADED;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOADED: begin
          // A new beat always wins over start and begins a fresh load at index 0.
          if (accept) begin
            idx   <= IW'(1);
            state <= IDLE;
          end
`ifndef FEEDER_AUTOSTART_EN
          else if (start) begin
            state      <= CLEAR;
            clear_out  <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
`endif
        end
        CLEAR: begin
          state     <= FEED;
          clear_out <= 1'b0;
          step      <= nxt_step;
          a_row     <= a_skew;
          b_col     <= b_skew;
        end
        FEED: begin
          if (step == LAST_STEP) begin
            state <= DONE;
            done  <= 1'b1;
            a_row <= '0;
            b_col <= '0;
          end else begin
            step  <= nxt_step;
            a_row <= a_skew;
            b_col <= b_skew;
          end
        end
        DONE: begin
          state      <= LOADED;
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder with a PE-array reference
module tb_systolic_feeder;

  localparam int W     = 8;
  localparam int N     = 2;
  localparam int STEPS = 3 * N - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] load_data = '0;
  logic load_ready, busy, done, clear_out;
  logic [N*W-1:0] a_row, b_col;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] ma [N][N];
  logic signed [W-1:0] mb [N][N];

  systolic_feeder #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .busy(busy), .done(done),
    .clear_out(clear_out), .a_row(a_row), .b_col(b_col)
  );

  always #5 clk = ~clk;

  // Downstream output-stationary PE array driven by the feeder outputs.
  logic signed [W-1:0] a_in [N][N];
  logic signed [W-1:0] b_in [N][N];
  logic signed [W-1:0] ar [N][N];
  logic signed [W-1:0] br [N][N];
  logic signed [31:0]  acc [N][N];

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      if (j == 0) begin : g_w
        assign a_in[i][j] = a_row[i*W +: W];
      end else begin : g_e
        assign a_in[i][j] = ar[i][j-1];
      end
      if (i == 0) begin : g_n
        assign b_in[i][j] = b_col[j*W +: W];
      end else begin : g_s
        assign b_in[i][j] = br[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (clear_out) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(a_in[i][j]) * 32'(b_in[i][j]);
          ar[i][j]  <= a_in[i][j];
          br[i][j]  <= b_in[i][j];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_ready);
    chk(tag, 64'({load_ready, busy, done, clear_out, a_row, b_col}),
        64'({exp_ready, 3'b000, {(2*N*W){1'b0}}}));
  endtask

  function automatic logic [N*W-1:0] exp_a(input int t);
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*W +: W] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_b(input int t);
    logic [N*W-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*W +: W] = mb[t-j][j];
    return v;
  endfunction

  function automatic logic signed [31:0] cexp(input int i, input int j);
    logic signed [31:0] s = '0;
    for (int k = 0; k < N; k++) s += 32'(ma[i][k]) * 32'(mb[k][j]);
    return s;
  endfunction

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
  endtask

  task automatic load_from(input int first);
    for (int e = first; e < 2*N*N; e++) begin
      load_valid = 1'b1;
      load_data  = (e < N*N) ? ma[e/N][e%N] : mb[(e-N*N)/N][(e-N*N)%N];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit use_start);
    if (use_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({tag, ".clear"}, 64'({clear_out, busy, load_ready, done, a_row, b_col}),
        64'({4'b1100, {(2*N*W){1'b0}}}));
    for (int t = 0; t < STEPS; t++) begin
      start = (t == 1);
      tick();
      chk($sformatf("%s.a%0d", tag, t), 64'(a_row), 64'(exp_a(t)));
      chk($sformatf("%s.b%0d", tag, t), 64'(b_col), 64'(exp_b(t)));
      chk($sformatf("%s.ctl%0d", tag, t), 64'({clear_out, done, busy}), 64'(3'b001));
    end
    start = 1'b0;
    tick();
    chk({tag, ".done"}, 64'({done, clear_out, busy, a_row, b_col}),
        64'({3'b101, {(2*N*W){1'b0}}}));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s.c%0d%0d", tag, i, j), 64'(acc[i][j]), 64'(cexp(i, j)));
    tick();
    chk({tag, ".after"}, 64'({done, busy, load_ready}), 64'(3'b001));
  endtask

  task automatic do_run(input string tag);
`ifdef FEEDER_AUTOSTART_EN
    run_seq(tag, 1'b0);
`else
    chk_quiet({tag, ".loaded"}, 1'b1);
    run_seq(tag, 1'b1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_quiet("reset", 1'b1);
    rst = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk_quiet("start_idle", 1'b1);

    ma = '{'{8'sd1, 8'sd2}, '{8'sd3, 8'sd4}};
    mb = '{'{8'sd5, 8'sd6}, '{8'sd7, 8'sd8}};
    load_from(0);
    do_run("dir");
    chk("dir.c00", 64'(acc[0][0]), 64'(19));
    chk("dir.c01", 64'(acc[0][1]), 64'(22));
    chk("dir.c10", 64'(acc[1][0]), 64'(43));
    chk("dir.c11", 64'(acc[1][1]), 64'(50));

`ifdef FEEDER_AUTOSTART_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_quiet("start_loaded_auto", 1'b1);
`else
    run_seq("rerun", 1'b1);
`endif

    rand_mats();
    load_valid = 1'b1;
    load_data  = ma[0][0];
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    chk_quiet("beat_start", 1'b1);
    load_from(1);
    do_run("beat_start");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = -8'sd128;
        mb[i][j] = 8'sd127;
      end
    load_from(0);
    do_run("extreme");
    chk("extreme.c00", 64'(acc[0][0]), 64'(-32512));

`ifdef FEEDER_AUTOSTART_EN
    load_from(0);
`else
    start = 1'b1;
    tick();
    start = 1'b0;
`endif
    tick();
    tick();
    chk("rst_feed.pre", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("rst_feed", 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_quiet("start_after_rst", 1'b1);

    rand_mats();
    for (int e = 0; e < 3; e++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("rst_load", 1'b1);
    load_from(0);
    do_run("reload");

    for (int r = 0; r < 4; r++) begin
      rand_mats();
      load_from(0);
      do_run($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
